mips_memory_access_controller: RTL and testbench
================================================

Name: mips_memory_access_controller

Overview:
Sequences the MEM-stage data-memory access for the pipelined MIPS core. It takes the per-instruction memory control (load/store, size, sign extension) and drives a request/acknowledge data-memory port. It stalls the pipeline while an access is outstanding and returns aligned, extended load data. It sits between the decoded memory control signals and the external data-memory interface.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width; fixed at 32, word = 4 bytes
TIMEOUT, 255, cycles to wait for memAck before raising busError; 0 disables the timeout

Ports:
clock  input  1  rising-edge clock
resetN  input  1  asynchronous active-low reset
load  input  1  MEM-stage instruction is a load; valid when advance=1
store  input  1  MEM-stage instruction is a store; load and store together is illegal and is treated as store
size  input  2  0=byte, 1=half, 2=word, 3=reserved and treated as word
signExtend  input  1  sign-extend a byte or half load
address  input  ADDR_W  effective byte address
writeData  input  DATA_W  store data, right-aligned
advance  input  1  pipeline moves this cycle
stall  output  1  holds IF through MEM
readData  output  DATA_W  extended load result, valid in the cycle done=1
done  output  1  access completed this cycle
misaligned  output  1  address exception pulse; no memory request is issued
busError  output  1  timeout pulse
memReq  output  1  request to memory
memWe  output  1  write enable
memAddr  output  ADDR_W  word-aligned address; low 2 bits are 0
memWdata  output  DATA_W  lane-replicated store data
memBe  output  4  byte enables
memAck  input  1  one-cycle completion from memory
memRdata  input  DATA_W  read word, valid with memAck

Behaviour:
- Reset: state=IDLE; all outputs 0; timeout counter 0. Reset asserted mid-access drops memReq immediately, and any later memAck is ignored.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Accept when load|store.
  - Misaligned if half with addr[0]=1, or word with addr[1:0]!=0. On misaligned: pulse misaligned for 1 cycle, stay IDLE, stall=0.
  - Otherwise latch the request, assert stall combinationally in the same cycle, and go to ACCESS.
- ACCESS:
  - Drive memReq=1 with registered memWe, memAddr, memBe and memWdata; these hold steady until memAck.
  - memAck=1: capture the formatted load data and go to DONE.
  - Counter reaches TIMEOUT without memAck: pulse busError, go to IDLE, deassert stall.
  - memAck in the same cycle as the timeout: ack wins.
- DONE:
  - done=1, stall=0, readData valid; go to IDLE next cycle.
  - A new request in DONE is not accepted until IDLE. This gives a one-bubble minimum, so access latency is ack latency + 2.
- Byte enables:
  - Byte: 1<<addr[1:0].
  - Half: 0011 or 1100, selected by addr[1].
  - Word: 1111.
- Store data replication: byte repeated into 4 lanes; half repeated into 2 lanes.
- Load formatting: select the lane from latched addr[1:0], then zero- or sign-extend per the latched signExtend. Word loads pass through unchanged.
- Stores still wait for memAck; readData is 0 for stores.
- memAck outside ACCESS is ignored.

Optional Feature:
MIPS_MEMORY_ACCESS_CONTROLLER_STORE_BUFFER_EN
- Enabled: a one-entry posted store buffer.
  - A store in IDLE with the buffer empty fills the buffer; stall=0 and done pulses the next cycle. The buffer drains via memReq in the background.
  - A new request while the buffer is occupied stalls until the drain's memAck.
  - A load whose word address matches the buffered store also stalls until the drain completes. No forwarding.
  - busError during a drain discards the entry.
- Disabled: stores block as described in Behaviour.

Decomposition:
- Shared package holds:
  - size encodings (Byte/Half/Word)
  - state encodings (IDLE/ACCESS/DONE)
  - byte-enable constants
  - the misalignment predicate macro
- Sub-module mips_memory_access_lane_format: purely combinational. Byte-enable generation, store replication and load extraction/extension; shared by the main path and the store buffer.

Test Plan:
1. lb: addr=0x1003, signExtend=1, memRdata=0x80112233, ack after 2 cycles -> memBe=1000, memAddr=0x1000, readData=0xFFFFFF80, stall high for 3 cycles.
2. sh: addr=0x2002, writeData=0x0000BEEF -> memWe=1, memBe=1100, memWdata=0xBEEFBEEF; lhu of the same address with memRdata=0xBEEF0000 -> readData=0x0000BEEF.
3. lw at addr=0x0006 -> misaligned pulses once, memReq never asserts, stall=0.
4. TIMEOUT=4 with no ack -> busError on cycle 4 of ACCESS, state returns to IDLE, stall drops.
5. resetN=0 while in ACCESS -> memReq=0 immediately; a late memAck -> no done.
6. With STORE_BUFFER_EN: sw 0x10 then lw 0x10 back-to-back -> the sw does not stall; the lw stalls until the drain ack; the store completes before the load's memReq.

Source files
------------

// File: rtl/mips_memory_access_controller_pkg.sv
// rtl/mips_memory_access_controller_pkg.sv - shared encodings and helpers for the MEM-stage access controller
package mips_memory_access_controller_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Reserved size 3 behaves as a word, so it shares the word alignment rule.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] offset);
        return ((sz == SIZE_HALF) && offset[0]) ||
               ((sz[1] == 1'b1) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/mips_memory_access_lane_format.sv
// rtl/mips_memory_access_lane_format.sv - byte enables, store lane replication and load extraction
module mips_memory_access_lane_format
    import mips_memory_access_controller_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_extend,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel    = rdata[{offset, 3'b000} +: 8];
        half_sel    = offset[1] ? rdata[31:16] : rdata[15:0];
        be          = BE_WORD;
        wdata_lanes = wdata;
        rdata_ext   = rdata;
        case (size)
            SIZE_BYTE: begin
                be          = BE_BYTE0 << offset;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {{24{sign_extend & byte_sel[7]}}, byte_sel};
            end
            SIZE_HALF: begin
                be          = offset[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {{16{sign_extend & half_sel[15]}}, half_sel};
            end
            default: begin
                be          = BE_WORD;
                wdata_lanes = wdata;
                rdata_ext   = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mips_memory_access_controller.sv
// rtl/mips_memory_access_controller.sv - MEM-stage data-memory sequencer; MIPS_MEMORY_ACCESS_CONTROLLER_STORE_BUFFER_EN adds a posted store buffer
module mips_memory_access_controller
    import mips_memory_access_controller_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              load,
    input  logic              store,
    input  logic [1:0]        size,
    input  logic              signExtend,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    input  logic              advance,
    output logic              stall,
    output logic [DATA_W-1:0] readData,
    output logic              done,
    output logic              misaligned,
    output logic              busError,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    output logic [3:0]        memBe,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e           state;
    logic [1:0]       lat_size;
    logic [1:0]       lat_offset;
    logic             lat_sign;
    logic [CNT_W-1:0] count;

    logic        req_valid;
    logic        mis;
    logic        timeout_hit;
    logic        blocked;
    logic        posted;
    logic [1:0]  fmt_size;
    logic [1:0]  fmt_offset;
    logic        fmt_sign;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_rdata;

    assign req_valid   = advance & (load | store);
    assign mis         = is_misaligned(size, address[1:0]);
    assign timeout_hit = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT - 1));

`ifdef MIPS_MEMORY_ACCESS_CONTROLLER_STORE_BUFFER_EN
    // The held memory-port registers are the single buffer entry; an
    // outstanding drain in IDLE means the entry is still occupied.
    assign blocked = memReq;
    assign posted  = store;
`else
    assign blocked = 1'b0;
    assign posted  = 1'b0;
`endif

    // One formatter serves both directions: live inputs when issuing, latched ones on ack.
    assign fmt_size   = (state == ST_IDLE) ? size         : lat_size;
    assign fmt_offset = (state == ST_IDLE) ? address[1:0] : lat_offset;
    assign fmt_sign   = (state == ST_IDLE) ? signExtend   : lat_sign;

    mips_memory_access_lane_format u_lane_format (
        .size        (fmt_size),
        .offset      (fmt_offset),
        .sign_extend (fmt_sign),
        .wdata       (writeData),
        .rdata       (memRdata),
        .be          (fmt_be),
        .wdata_lanes (fmt_wdata),
        .rdata_ext   (fmt_rdata)
    );

    assign stall = (state == ST_ACCESS) ||
                   ((state == ST_IDLE) && req_valid && !mis && (blocked || !posted));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state      <= ST_IDLE;
            readData   <= '0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            busError   <= 1'b0;
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= '0;
            memWdata   <= '0;
            memBe      <= 4'b0000;
            lat_size   <= SIZE_BYTE;
            lat_offset <= 2'b00;
            lat_sign   <= 1'b0;
            count      <= '0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            busError   <= 1'b0;

            // Port handshake is shared by blocking accesses and background drains.
            if (memReq) begin
                if (memAck) begin
                    memReq <= 1'b0;
                    count  <= '0;
                end else if (timeout_hit) begin
                    memReq   <= 1'b0;
                    busError <= 1'b1;
                    count    <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (mis) begin
                            misaligned <= 1'b1;
                        end else if (!blocked) begin
                            memReq     <= 1'b1;
                            memWe      <= store;
                            memAddr    <= {address[ADDR_W-1:2], 2'b00};
                            memBe      <= fmt_be;
                            memWdata   <= fmt_wdata;
                            lat_size   <= size;
                            lat_offset <= address[1:0];
                            lat_sign   <= signExtend;
                            readData   <= '0;
                            if (posted) begin
                                done <= 1'b1;
                            end else begin
                                state <= ST_ACCESS;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (memAck) begin
                        readData <= memWe ? '0 : fmt_rdata;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else if (timeout_hit) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    readData <= '0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_memory_access_controller.sv
// tb/tb_mips_memory_access_controller.sv - directed self-checking bench for mips_memory_access_controller
module tb_mips_memory_access_controller;
    import mips_memory_access_controller_pkg::*;

    logic        clock;
    logic        resetN;
    logic        load;
    logic        store;
    logic [1:0]  size;
    logic        signExtend;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        advance;
    logic        stall;
    logic [31:0] readData;
    logic        done;
    logic        misaligned;
    logic        busError;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memBe;
    logic        memAck;
    logic [31:0] memRdata;

    int checks = 0;
    int errors = 0;

    mips_memory_access_controller #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clock      (clock),
        .resetN     (resetN),
        .load       (load),
        .store      (store),
        .size       (size),
        .signExtend (signExtend),
        .address    (address),
        .writeData  (writeData),
        .advance    (advance),
        .stall      (stall),
        .readData   (readData),
        .done       (done),
        .misaligned (misaligned),
        .busError   (busError),
        .memReq     (memReq),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memWdata   (memWdata),
        .memBe      (memBe),
        .memAck     (memAck),
        .memRdata   (memRdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic present(input logic ld, input logic st, input logic [1:0] sz,
                           input logic se, input logic [31:0] a, input logic [31:0] wd);
        load = ld; store = st; size = sz; signExtend = se;
        address = a; writeData = wd; advance = 1'b1;
    endtask

    task automatic idle_inputs();
        load = 1'b0; store = 1'b0; size = 2'd0; signExtend = 1'b0;
        address = 32'h0; writeData = 32'h0; advance = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; memAck = 1'b0; memRdata = 32'h0;
        idle_inputs();
        step(); step();
        #1;
        check_eq("rst_stall", stall, 0);
        check_eq("rst_memReq", memReq, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_readData", readData, 0);
        check_eq("rst_memBe", memBe, 0);
        step(); resetN = 1'b1;

        // lb 0x1003 sign-extended, ack on second ACCESS cycle
        step(); present(1, 0, SIZE_BYTE, 1, 32'h1003, 0); #1;
        check_eq("lb_stall_c0", stall, 1);
        check_eq("lb_req_c0", memReq, 0);
        step(); #1;
        check_eq("lb_req", memReq, 1);
        check_eq("lb_addr", memAddr, 32'h1000);
        check_eq("lb_be", memBe, 32'h8);
        check_eq("lb_we", memWe, 0);
        check_eq("lb_stall_c1", stall, 1);
        step(); memAck = 1; memRdata = 32'h80112233; #1;
        check_eq("lb_stall_c2", stall, 1);
        step(); memAck = 0; idle_inputs(); #1;
        check_eq("lb_done", done, 1);
        check_eq("lb_data", readData, 32'hFFFFFF80);
        check_eq("lb_stall_done", stall, 0);
        check_eq("lb_req_done", memReq, 0);
        step(); #1;
        check_eq("lb_done_clr", done, 0);

        // sh 0x2002 then lhu 0x2002
        step(); present(0, 1, SIZE_HALF, 0, 32'h2002, 32'h0000BEEF); #1;
`ifdef MIPS_MEMORY_ACCESS_CONTROLLER_STORE_BUFFER_EN
        check_eq("sh_stall_post", stall, 0);
        step(); idle_inputs(); #1;
        check_eq("sh_done_post", done, 1);
        check_eq("sh_req", memReq, 1);
        check_eq("sh_we", memWe, 1);
        check_eq("sh_be", memBe, 32'hC);
        check_eq("sh_wdata", memWdata, 32'hBEEFBEEF);
        memAck = 1;
        step(); memAck = 0; #1;
        check_eq("sh_req_drained", memReq, 0);
`else
        check_eq("sh_stall", stall, 1);
        step(); idle_inputs(); #1;
        check_eq("sh_req", memReq, 1);
        check_eq("sh_we", memWe, 1);
        check_eq("sh_be", memBe, 32'hC);
        check_eq("sh_wdata", memWdata, 32'hBEEFBEEF);
        memAck = 1;
        step(); memAck = 0; #1;
        check_eq("sh_done", done, 1);
        check_eq("sh_readData", readData, 0);
        step();
`endif
        step(); present(1, 0, SIZE_HALF, 0, 32'h2002, 0); #1;
        check_eq("lhu_stall", stall, 1);
        step(); idle_inputs(); #1;
        check_eq("lhu_req", memReq, 1);
        check_eq("lhu_we", memWe, 0);
        check_eq("lhu_addr", memAddr, 32'h2000);
        memAck = 1; memRdata = 32'hBEEF0000;
        step(); memAck = 0; #1;
        check_eq("lhu_done", done, 1);
        check_eq("lhu_data", readData, 32'h0000BEEF);
        step();

        // misaligned lw and lh
        step(); present(1, 0, SIZE_WORD, 0, 32'h0006, 0); #1;
        check_eq("lw_mis_stall", stall, 0);
        step(); idle_inputs(); #1;
        check_eq("lw_mis_pulse", misaligned, 1);
        check_eq("lw_mis_req", memReq, 0);
        step(); #1;
        check_eq("lw_mis_clr", misaligned, 0);
        check_eq("lw_mis_req2", memReq, 0);
        present(1, 0, SIZE_HALF, 1, 32'h0001, 0); #1;
        check_eq("lh_mis_stall", stall, 0);
        step(); idle_inputs(); #1;
        check_eq("lh_mis_pulse", misaligned, 1);

        // timeout after 4 ACCESS cycles with no ack
        step(); present(1, 0, SIZE_WORD, 0, 32'h0040, 0); #1;
        check_eq("to_stall_c0", stall, 1);
        for (int i = 1; i <= 4; i++) begin
            step(); idle_inputs(); #1;
            check_eq($sformatf("to_req_c%0d", i), memReq, 1);
            check_eq($sformatf("to_berr_c%0d", i), busError, 0);
        end
        step(); #1;
        check_eq("to_berr", busError, 1);
        check_eq("to_req_drop", memReq, 0);
        check_eq("to_stall_drop", stall, 0);
        check_eq("to_no_done", done, 0);
        step(); #1;
        check_eq("to_berr_clr", busError, 0);

        // ack in the same cycle as the timeout wins
        step(); present(1, 0, SIZE_WORD, 0, 32'h0044, 0);
        step(); idle_inputs();
        step(); step(); step();
        memAck = 1; memRdata = 32'h11223344;
        step(); memAck = 0; #1;
        check_eq("ackwin_done", done, 1);
        check_eq("ackwin_berr", busError, 0);
        check_eq("ackwin_data", readData, 32'h11223344);
        step();

        // reset mid-access, then a late ack
        step(); present(1, 0, SIZE_WORD, 0, 32'h0080, 0);
        step(); idle_inputs(); #1;
        check_eq("rstacc_req", memReq, 1);
        resetN = 0; #1;
        check_eq("rstacc_req_drop", memReq, 0);
        check_eq("rstacc_stall", stall, 0);
        step(); resetN = 1; memAck = 1; memRdata = 32'hFFFFFFFF;
        step(); memAck = 0; #1;
        check_eq("late_ack_done", done, 0);
        check_eq("late_ack_data", readData, 0);
        check_eq("late_ack_req", memReq, 0);

`ifdef MIPS_MEMORY_ACCESS_CONTROLLER_STORE_BUFFER_EN
        // sw 0x10 posted, lw 0x10 waits for the drain
        step(); present(0, 1, SIZE_WORD, 0, 32'h0010, 32'h12345678); #1;
        check_eq("sb_sw_stall", stall, 0);
        step(); present(1, 0, SIZE_WORD, 0, 32'h0010, 0); #1;
        check_eq("sb_sw_done", done, 1);
        check_eq("sb_drain_req", memReq, 1);
        check_eq("sb_drain_we", memWe, 1);
        check_eq("sb_drain_addr", memAddr, 32'h10);
        check_eq("sb_lw_stall1", stall, 1);
        step(); memAck = 1; #1;
        check_eq("sb_lw_stall2", stall, 1);
        check_eq("sb_drain_we2", memWe, 1);
        step(); memAck = 0; #1;
        check_eq("sb_lw_req_c0", memReq, 0);
        check_eq("sb_lw_stall3", stall, 1);
        step(); idle_inputs(); #1;
        check_eq("sb_lw_req", memReq, 1);
        check_eq("sb_lw_we", memWe, 0);
        memAck = 1; memRdata = 32'hCAFE0001;
        step(); memAck = 0; #1;
        check_eq("sb_lw_done", done, 1);
        check_eq("sb_lw_data", readData, 32'hCAFE0001);
        check_eq("sb_lw_stall_end", stall, 0);
`else
        // sb 0x31 replicates the byte into all lanes
        step(); present(0, 1, SIZE_BYTE, 0, 32'h0031, 32'h000000A5); #1;
        check_eq("sb_stall", stall, 1);
        step(); idle_inputs(); #1;
        check_eq("sb_be", memBe, 32'h2);
        check_eq("sb_wdata", memWdata, 32'hA5A5A5A5);
        check_eq("sb_addr", memAddr, 32'h30);
        memAck = 1;
        step(); memAck = 0; #1;
        check_eq("sb_done", done, 1);
        check_eq("sb_readData", readData, 0);
`endif
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
